// File: rtl/wt_msg_arbiter.sv
// Message-level round-robin arbiter: shares one wt_unit slave port between N_REQ
// padder streams, holding each grant from the first accepted block until tlast.
module wt_msg_arbiter #(
    parameter int N_REQ             = 4,
    parameter int S_AXIS_DATA_WIDTH = 512,
    parameter int TUSER_WIDTH       = 128,
    parameter int ID_LSB            = 48,
    parameter int ID_WIDTH          = 3
) (
    input  logic                                 axis_aclk,
    input  logic                                 axis_resetn,
    input  logic [N_REQ*S_AXIS_DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic [N_REQ*TUSER_WIDTH-1:0]         s_axis_tuser,
    input  logic [N_REQ-1:0]                     s_axis_tvalid,
    output logic [N_REQ-1:0]                     s_axis_tready,
    input  logic [N_REQ-1:0]                     s_axis_tlast,
    output logic [S_AXIS_DATA_WIDTH-1:0]         m_axis_tdata,
    output logic [TUSER_WIDTH-1:0]               m_axis_tuser,
    output logic                                 m_axis_tvalid,
    input  logic                                 m_axis_tready,
    output logic                                 m_axis_tlast,
    output logic [ID_WIDTH-1:0]                  grant_id,
    output logic                                 busy,
    output logic [15:0]                          msg_count
);

    // state | meaning
    // IDLE  | no grant; every ready and all master outputs held at 0
    // BUSY  | grant locked to grant_q until the tlast handshake
    typedef enum logic {IDLE, BUSY} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_WIDTH-1:0] grant_q;
    logic [ID_WIDTH-1:0] last_served;
    logic [ID_WIDTH-1:0] pick;
    logic                pick_vld;
    logic [15:0]         msg_cnt;
    logic                msg_end;

    // First valid requester at or after last_served+1, wrapping modulo N_REQ.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = 1; k <= N_REQ; k++) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (!pick_vld && s_axis_tvalid[r] &&
                    (r == (int'(last_served) + k) % N_REQ)) begin
                    pick     = ID_WIDTH'(r);
                    pick_vld = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (pick_vld) state_nxt = BUSY;
            BUSY: if (msg_end)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk or negedge axis_resetn) begin
        if (!axis_resetn) begin
            grant_q     <= '0;
            last_served <= ID_WIDTH'(N_REQ - 1);
            msg_cnt     <= '0;
        end else begin
            if (state == IDLE && pick_vld) begin
                grant_q <= pick;
            end
            if (msg_end) begin
                last_served <= grant_q;
                msg_cnt     <= msg_cnt + 16'd1;
            end
        end
    end

    // Pure mux from the registered grant: no data register, zero-cycle backpressure.
    always_comb begin
        s_axis_tready = '0;
        m_axis_tvalid = 1'b0;
        m_axis_tlast  = 1'b0;
        m_axis_tdata  = '0;
        m_axis_tuser  = '0;
        if (state == BUSY) begin
            for (int r = 0; r < N_REQ; r++) begin
                if (grant_q == ID_WIDTH'(r)) begin
                    s_axis_tready[r] = m_axis_tready;
                    m_axis_tvalid    = s_axis_tvalid[r];
                    m_axis_tlast     = s_axis_tlast[r];
                    m_axis_tdata     = s_axis_tdata[r*S_AXIS_DATA_WIDTH +: S_AXIS_DATA_WIDTH];
                    m_axis_tuser     = s_axis_tuser[r*TUSER_WIDTH +: TUSER_WIDTH];
                    m_axis_tuser[ID_LSB +: ID_WIDTH] = grant_q;
                end
            end
        end
    end

    assign msg_end   = m_axis_tvalid & m_axis_tready & m_axis_tlast;
    assign busy      = (state == BUSY);
    assign grant_id  = grant_q;
    assign msg_count = msg_cnt;

endmodule
